trace_item_buffer: RTL and testbench
====================================

# trace_item_buffer

Sits directly downstream of the trace filter and captures every instruction the filter keeps (`pc_valid && !drop_instr`) into a small first-word-fall-through FIFO. Each captured instruction is tagged with its PC, its encoding, the cycle delta since the previous kept instruction, and a lost-data flag. Entries drain through a valid/ready interface towards the trace packer/DMA path. The block decouples the bursty branch/jump stream from a back-pressured consumer and reports overflow instead of stalling the core.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `PC_WIDTH`, 64: program counter width.
- `DELTA_WIDTH`, 16: cycle-delta field width; saturating.
- `CNT_WIDTH`, 16: overflow counter width; saturating.
- `clk`  in  1  single clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_valid`  in  1  core retired an instruction this cycle.
- `pc`  in  PC_WIDTH  PC of that instruction.
- `instr`  in  RISC_V_INSTRUCTION_WIDTH  instruction encoding.
- `drop_instr`  in  1  from trace filter; 1 = do not record.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head entry.
- `out_item`  out  trace_item_t  head entry {pc, instr, delta, lost}.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow_count`  out  CNT_WIDTH  kept instructions discarded because the FIFO was full.

## Operation
- `keep = pc_valid && !drop_instr`.
- `pop = out_valid && out_ready`.
- `push = keep && (!full || pop)`. A push while full succeeds only when a pop happens in the same cycle; level is unchanged.
- `keep && !push` is an overflow event:
  - `overflow_count` increments, saturating at all-ones.
  - Sticky `lost_pending` is set.
- Delta counter `dcnt` (DELTA_WIDTH):
  - Increments every cycle, saturating at all-ones.
  - On `keep`, whether pushed or dropped, the captured delta is the current `dcnt` and `dcnt` loads 1.
  - Result: back-to-back kept instructions yield delta = 1.
  - The first kept instruction after reset carries the number of cycles since reset release.
- Entry `lost` bit:
  - Set to `lost_pending` at push time. `lost_pending` clears on that push.
  - If an overflow and a push coincide (only possible while full with no pop, which by definition is not a push), the overflow wins.
- FIFO storage:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - `level` is tracked separately; full = (level == DEPTH), empty = (level == 0).
- `out_item` holds the head entry whenever `out_valid` = 1 and is don't-care otherwise.
- `out_item` and `out_valid` must remain stable while `out_valid && !out_ready`.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `out_valid` = 0, `level` = 0, `overflow_count` = 0.
  - `dcnt` = 0, `lost_pending` = 0, pointers = 0.
  - Storage contents are not reset.
- Reset asserted mid-operation discards all entries immediately. No partial pop is visible.
- Push latency is one cycle: an entry pushed on edge N has `out_valid` = 1 after edge N. There is no same-cycle bypass when empty.
- A pop on edge N advances the head; the next entry, if any, is presented after edge N.
- Push and pop in the same cycle: level is unchanged, both pointers advance.
- Push and pop on an empty FIFO cannot happen in the same cycle, since `out_valid` = 0.
- Sustained throughput is 1 entry per cycle in and out.

## Structure
- Add to `continuous_monitoring_system_pkg`:
  - `trace_item_t`: packed struct {pc, instr, delta, lost}, widths from the package constants.
  - `TRACE_DELTA_WIDTH` default.
- Sub-module `trace_fifo`: generic synchronous FWFT FIFO.
  - Parameterised by width and depth, with push/pop/full/empty/level.
  - Instantiated with `$bits(trace_item_t)`.
- Delta, overflow and lost logic stay in `trace_item_buffer`.

## Test plan
- Reset release, then `keep` on cycle 5 with pc=0x8000_0000 and `out_ready`=1:
  - Item appears the next cycle with delta=5 and lost=0.
  - `level` returns to 0 after the pop.
- Three consecutive kept instructions followed by `drop_instr`=1 for 10 cycles, then a keep:
  - Deltas are 1, 1, 11 for the last three captured items.
- `out_ready`=0, 20 keeps with DEPTH=16:
  - `level`=16 and `overflow_count`=4.
  - Then set `out_ready`=1 and keep once: all 16 original items drain in order.
  - The new item has lost=1 and delta includes the dropped keeps' resets.
- Full FIFO with `out_ready`=1 and `keep` in the same cycle:
  - Push accepted, `level` stays 16, `overflow_count` unchanged.
- Back-pressure stability: hold `out_ready`=0 for 7 cycles with `out_valid`=1; `out_item` is unchanged throughout.
- Assert `rst_n`=0 asynchronously mid-cycle with `level`=9:
  - Outputs zero immediately.
  - After release, the first keep has a delta equal to the cycles since release.

Source files
------------

// File: rtl/continuous_monitoring_system_pkg.sv
// rtl/continuous_monitoring_system_pkg.sv - shared widths and trace item record
package continuous_monitoring_system_pkg;

  localparam int RISC_V_INSTRUCTION_WIDTH = 32;
  localparam int TRACE_PC_WIDTH           = 64;
  localparam int TRACE_DELTA_WIDTH        = 16;
  localparam int TRACE_CNT_WIDTH          = 16;

  typedef struct packed {
    logic [TRACE_PC_WIDTH-1:0]           pc;
    logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
    logic [TRACE_DELTA_WIDTH-1:0]        delta;
    logic                                lost;
  } trace_item_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - generic first-word-fall-through FIFO, occupancy tracked apart from pointers
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rptr_q];

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/trace_item_buffer.sv
// rtl/trace_item_buffer.sv - tags kept instructions with cycle delta and loss flag, buffers them for the packer
module trace_item_buffer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int PC_WIDTH    = TRACE_PC_WIDTH,
  parameter int DELTA_WIDTH = TRACE_DELTA_WIDTH,
  parameter int CNT_WIDTH   = TRACE_CNT_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                pc_valid,
  input  logic [PC_WIDTH-1:0]                 pc,
  input  logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr,
  input  logic                                drop_instr,
  output logic                                out_valid,
  input  logic                                out_ready,
  output trace_item_t                         out_item,
  output logic [$clog2(DEPTH):0]              level,
  output logic [CNT_WIDTH-1:0]                overflow_count
);

  logic                   keep, pop, push, overflow;
  logic                   full, empty;
  logic [DELTA_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [CNT_WIDTH-1:0]   ovf_q, ovf_d;
  logic                   lost_pending_q, lost_pending_d;
  trace_item_t            in_item;

  assign keep      = pc_valid && !drop_instr;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = keep && (!full || pop);
  assign overflow  = keep && !push;

  always_comb begin
    in_item.pc    = TRACE_PC_WIDTH'(pc);
    in_item.instr = instr;
    in_item.delta = TRACE_DELTA_WIDTH'(dcnt_q);
    in_item.lost  = lost_pending_q;
  end

  always_comb begin
    dcnt_d = (&dcnt_q) ? dcnt_q : dcnt_q + DELTA_WIDTH'(1);
    // Every kept instruction restarts the delta, even one that is then dropped.
    if (keep) dcnt_d = DELTA_WIDTH'(1);

    ovf_d = ovf_q;
    if (overflow && !(&ovf_q)) ovf_d = ovf_q + CNT_WIDTH'(1);

    lost_pending_d = lost_pending_q;
    if (overflow)  lost_pending_d = 1'b1;
    else if (push) lost_pending_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q         <= '0;
      ovf_q          <= '0;
      lost_pending_q <= 1'b0;
    end else begin
      dcnt_q         <= dcnt_d;
      ovf_q          <= ovf_d;
      lost_pending_q <= lost_pending_d;
    end
  end

  assign overflow_count = ovf_q;

  trace_fifo #(
    .WIDTH ($bits(trace_item_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_item),
    .pop       (pop),
    .pop_data  (out_item),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

endmodule

// File: tb/tb_trace_item_buffer.sv
// tb/tb_trace_item_buffer.sv - directed table and sequence checks for trace_item_buffer
module tb_trace_item_buffer;
  import continuous_monitoring_system_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_valid = 1'b0;
  logic [63:0] pc = '0;
  logic [31:0] instr = '0;
  logic        drop_instr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  trace_item_t out_item;
  logic [4:0]  level;
  logic [15:0] overflow_count;

  int checks = 0;
  int failures = 0;

  trace_item_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_valid       (pc_valid),
    .pc             (pc),
    .instr          (instr),
    .drop_instr     (drop_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_item       (out_item),
    .level          (level),
    .overflow_count (overflow_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        d;
    logic        r;
    logic [63:0] pc;
    logic        ev;
    logic [4:0]  el;
    logic        ci;
    logic [15:0] ed;
    logic        elost;
    logic [63:0] epc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc(input logic [63:0] p);
    return p[31:0] ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_item(input string name, input logic [63:0] epc, input logic [15:0] ed,
                          input logic elost);
    chk({name, ".valid"}, 64'(out_valid), 64'd1);
    chk({name, ".pc"}, out_item.pc, epc);
    chk({name, ".instr"}, 64'(out_item.instr), 64'(enc(epc)));
    chk({name, ".delta"}, 64'(out_item.delta), 64'(ed));
    chk({name, ".lost"}, 64'(out_item.lost), 64'(elost));
  endtask

  task automatic drive(input logic v, input logic d, input logic r, input logic [63:0] p);
    pc_valid = v; drop_instr = d; out_ready = r; pc = p; instr = enc(p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic v, input logic d, input logic r, input logic [63:0] p,
                              input logic ev, input logic [4:0] el, input logic ci,
                              input logic [15:0] ed, input logic elost, input logic [63:0] epc);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.pc = p; x.ev = ev; x.el = el;
    x.ci = ci; x.ed = ed; x.elost = elost; x.epc = epc;
    return x;
  endfunction

  initial begin
    // Table: first keep after reset, then three back-to-back keeps, ten filtered, one keep.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 64'h8000_0000, 1, 1, 1, 5, 0, 64'h8000_0000));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 64'h100, 1, 1, 1, 2, 0, 64'h100));
    vecs.push_back(mk(1, 0, 1, 64'h104, 1, 1, 1, 1, 0, 64'h104));
    vecs.push_back(mk(1, 0, 1, 64'h108, 1, 1, 1, 1, 0, 64'h108));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(1, 1, 1, 64'h300 + 64'(i), 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 64'h200, 1, 1, 1, 11, 0, 64'h200));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    do_reset();
    #1;
    chk("reset.valid", 64'(out_valid), 64'd0);
    chk("reset.level", 64'(level), 64'd0);
    chk("reset.ovf", 64'(overflow_count), 64'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].pc);
      tick();
      chk($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d.level", i), 64'(level), 64'(vecs[i].el));
      chk($sformatf("vec%0d.ovf", i), 64'(overflow_count), 64'd0);
      if (vecs[i].ci) chk_item($sformatf("vec%0d", i), vecs[i].epc, vecs[i].ed, vecs[i].elost);
    end

    // Overflow: 20 keeps into a stalled FIFO, then full+pop+keep, then drain in order.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 64'h1000 + 64'(4 * i));
      tick();
    end
    chk("ovf.level", 64'(level), 64'd16);
    chk("ovf.count", 64'(overflow_count), 64'd4);
    chk("ovf.head_pc", out_item.pc, 64'h1000);
    drive(1, 0, 1, 64'h2000);
    tick();
    chk("fullpop.level", 64'(level), 64'd16);
    chk("fullpop.count", 64'(overflow_count), 64'd4);
    drive(0, 0, 1, 64'd0);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain%0d.pc", i), out_item.pc, 64'h1000 + 64'(4 * i));
      chk($sformatf("drain%0d.lost", i), 64'(out_item.lost), 64'd0);
      tick();
    end
    chk_item("newitem", 64'h2000, 16'd1, 1'b1);
    tick();
    chk("drained.level", 64'(level), 64'd0);
    chk("drained.valid", 64'(out_valid), 64'd0);

    // Back-pressure: head must hold while nine more keeps land behind it.
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 64'h4000 + 64'(8 * i));
      tick();
      chk_item($sformatf("hold%0d", i), 64'h4000, 16'd17, 1'b0);
    end
    chk("hold.level", 64'(level), 64'd9);
    chk("hold.ovf", 64'(overflow_count), 64'd4);

    // Asynchronous reset in the middle of a cycle.
    drive(0, 0, 0, 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", 64'(out_valid), 64'd0);
    chk("arst.level", 64'(level), 64'd0);
    chk("arst.ovf", 64'(overflow_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    drive(1, 0, 0, 64'h5000);
    tick();
    chk_item("postrst", 64'h5000, 16'd3, 1'b0);
    chk("postrst.level", 64'(level), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
